// File: rtl/maze_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maze_decoder_pkg
// Purpose  : Shared definitions for the maze decoder: grid geometry, idle
//            word, input word field layout, cell layout and FSM encoding.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package maze_decoder_pkg;

  localparam int          GRID_W_DEF    = 5;
  localparam int          GRID_H_DEF    = 4;
  localparam logic [15:0] IDLE_WORD_DEF = 16'hF800;

  // Input word layout, MSB first: [15:14] rsvd, [13] done, [12] robot,
  // [11:10] treasure, [9:6] walls N,E,S,W, [5:3] y, [2:0] x.
  typedef struct packed {
    logic [1:0] rsvd;
    logic       done;
    logic       robot;
    logic [1:0] treasure;
    logic [3:0] walls;
    logic [2:0] y;
    logic [2:0] x;
  } word_t;

  // Cell layout: {visited, treasure[1:0], walls N,E,S,W}
  localparam int CELL_W = 7;

  // FSM encoding
  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_COMMIT    = 2'd2;

  function automatic logic [CELL_W-1:0] make_cell(input word_t w);
    return {1'b1, w.treasure, w.walls};
  endfunction

endpackage
`default_nettype wire

// File: rtl/maze_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : maze_decoder_if
// Purpose  : Bundles the maze decoder word input, read port and status
//            outputs.
// Ports    : in_word (16), read_x/read_y (3) -> read_cell (7),
//            robot_x/robot_y (3), done, word_count (8), err_count (8)
// Revision : 1.0 - initial release
// ============================================================================
interface maze_decoder_if;
  logic [15:0] in_word;
  logic [2:0]  read_x;
  logic [2:0]  read_y;
  logic [6:0]  read_cell;
  logic [2:0]  robot_x;
  logic [2:0]  robot_y;
  logic        done;
  logic [7:0]  word_count;
  logic [7:0]  err_count;

  modport master (
    output in_word, read_x, read_y,
    input  read_cell, robot_x, robot_y, done, word_count, err_count
  );

  modport slave (
    input  in_word, read_x, read_y,
    output read_cell, robot_x, robot_y, done, word_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/maze_grid_ram.sv
`default_nettype none
// ============================================================================
// Module   : maze_grid_ram
// Purpose  : GRID_W x GRID_H cell store. One synchronous write port, one
//            combinational read port, asynchronous active-low clear.
//            Reads outside the grid return zero.
// Ports    : clk_i, rst_ni, we_i, wx_i/wy_i (3), wdata_i (CELL_W),
//            rx_i/ry_i (3), rdata_o (CELL_W)
// Revision : 1.0 - initial release
// ============================================================================
module maze_grid_ram #(
  parameter int GRID_W = 5,
  parameter int GRID_H = 4,
  parameter int CELL_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [2:0]        wx_i,
  input  logic [2:0]        wy_i,
  input  logic [CELL_W-1:0] wdata_i,
  input  logic [2:0]        rx_i,
  input  logic [2:0]        ry_i,
  output logic [CELL_W-1:0] rdata_o
);

  localparam int N_CELLS = GRID_W * GRID_H;

  // Each cell contributes its value only when addressed, so an address
  // outside the grid selects nothing and the OR below yields zero.
  logic [CELL_W-1:0] rd_terms_w [N_CELLS];

  for (genvar gy = 0; gy < GRID_H; gy++) begin : g_row
    for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
      logic [CELL_W-1:0] cell_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cell_q <= '0;
        end else if (we_i && (wx_i == 3'(gx)) && (wy_i == 3'(gy))) begin
          cell_q <= wdata_i;
        end
      end

      assign rd_terms_w[gy*GRID_W + gx] =
        ((rx_i == 3'(gx)) && (ry_i == 3'(gy))) ? cell_q : '0;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      rdata_o = rdata_o | rd_terms_w[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/maze_decoder.sv
`default_nettype none
// ============================================================================
// Module   : maze_decoder
// Purpose  : Accepts maze-exploration words from an upstream deserializer,
//            one per IDLE_WORD-separated hold, and records cell contents,
//            robot position, completion and accepted/rejected word counts.
// Ports    : clk_i, rst_ni (async, active low)
//            bus (maze_decoder_if.slave): in_word, read_x/read_y ->
//            read_cell, robot_x/robot_y, done, word_count, err_count
// Revision : 1.0 - initial release
// ============================================================================
module maze_decoder
  import maze_decoder_pkg::*;
#(
  parameter int          GRID_W    = GRID_W_DEF,
  parameter int          GRID_H    = GRID_H_DEF,
  parameter logic [15:0] IDLE_WORD = IDLE_WORD_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  maze_decoder_if.slave bus
);

  localparam logic [3:0] GW = 4'(GRID_W);
  localparam logic [3:0] GH = 4'(GRID_H);

  word_t      in_q;
  word_t      cmd_q;
  logic [1:0] state_q, state_d;
  logic [2:0] robot_x_q, robot_y_q;
  logic       done_q;
  logic [7:0] word_cnt_q, err_cnt_q;

  logic in_idle_w, valid_w, commit_w, wr_en_w;

  assign in_idle_w = (in_q == word_t'(IDLE_WORD));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_IDLE: if (in_idle_w)  state_d = ST_ARMED;
      ST_ARMED:     if (!in_idle_w) state_d = ST_COMMIT;
      ST_COMMIT:                    state_d = ST_WAIT_IDLE;
      default:                      state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_q    <= '0;
      cmd_q   <= '0;
      state_q <= ST_WAIT_IDLE;
    end else begin
      in_q    <= word_t'(bus.in_word);
      state_q <= state_d;
      // Latch the word on ARMED exit so COMMIT acts on it even if the
      // upstream value has already moved on.
      if (state_q == ST_ARMED && !in_idle_w) begin
        cmd_q <= in_q;
      end
    end
  end

  assign commit_w = (state_q == ST_COMMIT);
  assign valid_w  = ({1'b0, cmd_q.x} < GW) && ({1'b0, cmd_q.y} < GH) &&
                    (cmd_q.rsvd == 2'b00);
  assign wr_en_w  = commit_w && valid_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      robot_x_q  <= '0;
      robot_y_q  <= '0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (commit_w) begin
      if (valid_w) begin
        word_cnt_q <= word_cnt_q + 8'd1;
        if (cmd_q.robot) begin
          robot_x_q <= cmd_q.x;
          robot_y_q <= cmd_q.y;
        end
        if (cmd_q.done) begin
          done_q <= 1'b1;
        end
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  maze_grid_ram #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CELL_W (CELL_W)
  ) u_grid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_en_w),
    .wx_i    (cmd_q.x),
    .wy_i    (cmd_q.y),
    .wdata_i (make_cell(cmd_q)),
    .rx_i    (bus.read_x),
    .ry_i    (bus.read_y),
    .rdata_o (bus.read_cell)
  );

  assign bus.robot_x    = robot_x_q;
  assign bus.robot_y    = robot_y_q;
  assign bus.done       = done_q;
  assign bus.word_count = word_cnt_q;
  assign bus.err_count  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_decoder
// Purpose  : Directed self-checking bench for maze_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_decoder;

  localparam logic [15:0] IDLE = 16'hF800;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  maze_decoder_if bus ();

  maze_decoder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a word and let n rising edges pass; leaves time at edge + 1.
  task automatic hold(input logic [15:0] w, input int n);
    bus.in_word = w;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full acceptance: idle separator, then the word held long enough.
  task automatic accept(input logic [15:0] w);
    hold(IDLE, 2);
    hold(w, 4);
  endtask

  task automatic peek(input logic [2:0] x, input logic [2:0] y);
    bus.read_x = x;
    bus.read_y = y;
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.in_word = 16'h0000;
    bus.read_x  = 3'd0;
    bus.read_y  = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.robot_x, bus.robot_y, bus.done} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_robot_done: got %b expected 0", {bus.robot_x, bus.robot_y, bus.done});
    end
    n_cmp++;
    if ({bus.word_count, bus.err_count} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counts: got %h expected 0000", {bus.word_count, bus.err_count});
    end
    peek(3'd4, 3'd3);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL reset_cell43: got %b expected 0", bus.read_cell);
    end
  endtask

  task automatic test_scenario1();
    do_reset();
    hold(IDLE, 2);
    hold(16'h1A4B, 10);
    peek(3'd3, 3'd1);
    n_cmp++;
    if (bus.read_cell !== 7'b1101001) begin
      n_err++;
      $display("FAIL s1_cell31: got %b expected 1101001", bus.read_cell);
    end
    n_cmp++;
    if ({bus.robot_x, bus.robot_y} !== {3'd3, 3'd1}) begin
      n_err++;
      $display("FAIL s1_robot: got %0d/%0d expected 3/1", bus.robot_x, bus.robot_y);
    end
    n_cmp++;
    if (bus.word_count !== 8'd1 || bus.done !== 1'b0 || bus.err_count !== 8'd0) begin
      n_err++;
      $display("FAIL s1_status: got wc=%0d done=%b ec=%0d expected 1/0/0",
               bus.word_count, bus.done, bus.err_count);
    end
  endtask

  // New word on IN before edge 1; cell must be old after edge 2 (write in
  // flight, same-cycle read gives old value) and new after edge 3.
  task automatic test_latency();
    do_reset();
    hold(IDLE, 2);
    bus.read_x = 3'd1;
    bus.read_y = 3'd1;
    hold(16'h0009, 2);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL latency_edge2: got %b expected 0000000", bus.read_cell);
    end
    hold(16'h0009, 1);
    n_cmp++;
    if (bus.read_cell !== 7'b1000000) begin
      n_err++;
      $display("FAIL latency_edge3: got %b expected 1000000", bus.read_cell);
    end
  endtask

  task automatic test_done_sticky();
    do_reset();
    accept(16'h2000);
    peek(3'd0, 3'd0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.read_cell !== 7'b1000000) begin
      n_err++;
      $display("FAIL s2_done_set: got done=%b cell=%b expected 1/1000000", bus.done, bus.read_cell);
    end
    accept(16'h0001);
    accept(16'h0012);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.word_count !== 8'd3) begin
      n_err++;
      $display("FAIL s2_done_sticky: got done=%b wc=%0d expected 1/3", bus.done, bus.word_count);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    accept(16'h1A4B);
    accept(16'h004B);
    peek(3'd3, 3'd1);
    n_cmp++;
    if (bus.read_cell !== 7'b1000001) begin
      n_err++;
      $display("FAIL overwrite_cell31: got %b expected 1000001", bus.read_cell);
    end
    n_cmp++;
    if ({bus.robot_x, bus.robot_y} !== {3'd3, 3'd1} || bus.word_count !== 8'd2) begin
      n_err++;
      $display("FAIL overwrite_robot_wc: got %0d/%0d wc=%0d expected 3/1 wc=2",
               bus.robot_x, bus.robot_y, bus.word_count);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    accept(16'h0005);
    n_cmp++;
    if (bus.err_count !== 8'd1 || bus.word_count !== 8'd0) begin
      n_err++;
      $display("FAIL s3_x5: got ec=%0d wc=%0d expected 1/0", bus.err_count, bus.word_count);
    end
    peek(3'd0, 3'd0);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL s3_cell00: got %b expected 0", bus.read_cell);
    end
    accept(16'h0020);
    accept(16'h7000);
    n_cmp++;
    if (bus.err_count !== 8'd3 || bus.done !== 1'b0 ||
        {bus.robot_x, bus.robot_y} !== 6'd0 || bus.word_count !== 8'd0) begin
      n_err++;
      $display("FAIL invalid_y_rsvd: got ec=%0d done=%b robot=%0d/%0d wc=%0d expected 3/0/0/0/0",
               bus.err_count, bus.done, bus.robot_x, bus.robot_y, bus.word_count);
    end
  endtask

  task automatic test_read_range();
    do_reset();
    accept(16'h0FDC);
    peek(3'd4, 3'd3);
    n_cmp++;
    if (bus.read_cell !== 7'h7F) begin
      n_err++;
      $display("FAIL read_cell43: got %b expected 1111111", bus.read_cell);
    end
    peek(3'd5, 3'd3);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL read_x5: got %b expected 0", bus.read_cell);
    end
    peek(3'd4, 3'd4);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL read_y4: got %b expected 0", bus.read_cell);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hold(IDLE, 2);
    hold(16'h0001, 4);
    hold(16'h0002, 4);
    hold(IDLE, 1);
    n_cmp++;
    if (bus.word_count !== 8'd1 || bus.err_count !== 8'd0) begin
      n_err++;
      $display("FAIL s4_counts: got wc=%0d ec=%0d expected 1/0", bus.word_count, bus.err_count);
    end
    peek(3'd1, 3'd0);
    n_cmp++;
    if (bus.read_cell !== 7'b1000000) begin
      n_err++;
      $display("FAIL s4_cell10: got %b expected 1000000", bus.read_cell);
    end
    peek(3'd2, 3'd0);
    n_cmp++;
    if (bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL s4_cell20: got %b expected 0", bus.read_cell);
    end
  endtask

  task automatic test_saturate_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) accept(16'h0007);
    n_cmp++;
    if (bus.err_count !== 8'd255) begin
      n_err++;
      $display("FAIL s5_ec255: got %0d expected 255", bus.err_count);
    end
    for (int i = 0; i < 45; i++) accept(16'h0007);
    n_cmp++;
    if (bus.err_count !== 8'd255 || bus.word_count !== 8'd0) begin
      n_err++;
      $display("FAIL s5_ec_sat: got ec=%0d wc=%0d expected 255/0", bus.err_count, bus.word_count);
    end
    for (int i = 0; i < 255; i++) accept(16'h0000);
    n_cmp++;
    if (bus.word_count !== 8'd255) begin
      n_err++;
      $display("FAIL s5_wc255: got %0d expected 255", bus.word_count);
    end
    accept(16'h0000);
    n_cmp++;
    if (bus.word_count !== 8'd0 || bus.err_count !== 8'd255) begin
      n_err++;
      $display("FAIL s5_wc_wrap: got wc=%0d ec=%0d expected 0/255", bus.word_count, bus.err_count);
    end
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    accept(16'h1A4B);
    accept(16'h0007);
    hold(IDLE, 2);
    bus.read_x  = 3'd3;
    bus.read_y  = 3'd1;
    bus.in_word = 16'h2000;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.robot_x, bus.robot_y, bus.done} !== 7'd0 ||
        {bus.word_count, bus.err_count} !== 16'd0 || bus.read_cell !== 7'd0) begin
      n_err++;
      $display("FAIL s6_async_clear: got robot=%0d/%0d done=%b wc=%0d ec=%0d cell=%b expected all 0",
               bus.robot_x, bus.robot_y, bus.done, bus.word_count, bus.err_count, bus.read_cell);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    peek(3'd0, 3'd0);
    n_cmp++;
    if (bus.read_cell !== 7'd0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL s6_no_write: got cell00=%b done=%b expected 0/0", bus.read_cell, bus.done);
    end
    // After release a word is not taken until an idle word has been seen.
    hold(16'h0009, 6);
    n_cmp++;
    if (bus.word_count !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset_no_idle: got wc=%0d expected 0", bus.word_count);
    end
    accept(16'h0009);
    peek(3'd1, 3'd1);
    n_cmp++;
    if (bus.word_count !== 8'd1 || bus.read_cell !== 7'b1000000) begin
      n_err++;
      $display("FAIL post_reset_accept: got wc=%0d cell=%b expected 1/1000000",
               bus.word_count, bus.read_cell);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.in_word = 16'h0000;
    bus.read_x  = 3'd0;
    bus.read_y  = 3'd0;
    test_reset();
    test_scenario1();
    test_latency();
    test_done_sticky();
    test_overwrite();
    test_invalid();
    test_read_range();
    test_back_to_back();
    test_saturate_wrap();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
